// File: rtl/demux1_8_serial_rx.sv
// Serial-to-parallel frame receiver: rebuilds N-bit words from a one-bit-per-beat
// stream, using sof for alignment and flagging framing violations.
module demux1_8_serial_rx #(
  parameter int N  = 8,
  parameter int SW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic          in_bit,
  input  logic          sof,
  output logic [N-1:0]  out,
  output logic          out_valid,
  output logic [SW-1:0] s,
  output logic          locked,
  output logic          sync_err
);

  typedef enum logic {HUNT, LOCKED} state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] s_q, s_d;
  logic [N-1:0]  shadow_q, shadow_d;
  logic [N-1:0]  out_q, out_d;
  logic          out_valid_q, out_valid_d;
  logic          sync_err_q, sync_err_d;

  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    shadow_d    = shadow_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    sync_err_d  = 1'b0;
    if (in_valid) begin
      case (state_q)
        HUNT: begin
          if (sof) begin
            shadow_d[0] = in_bit;
            s_d         = SW'(1);
            state_d     = LOCKED;
          end
        end
        LOCKED: begin
          if (sof) begin
            // An sof anywhere but slot 0 drops the partial frame and realigns here.
            sync_err_d  = (s_q != '0);
            shadow_d[0] = in_bit;
            s_d         = SW'(1);
          end else if (s_q == '0) begin
            sync_err_d = 1'b1;
            state_d    = HUNT;
            s_d        = '0;
          end else begin
            shadow_d[s_q] = in_bit;
            s_d           = s_q + SW'(1);
            if (&s_q) begin
              out_d       = {in_bit, shadow_q[N-2:0]};
              out_valid_d = 1'b1;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      s_q         <= '0;
      shadow_q    <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      shadow_q    <= shadow_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      sync_err_q  <= sync_err_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign s         = s_q;
  assign locked    = (state_q == LOCKED);
  assign sync_err  = sync_err_q;

endmodule

// File: tb/tb_demux1_8_serial_rx.sv
// Scoreboard bench for demux1_8_serial_rx: frames push expected words, a
// negedge monitor pops them on each out_valid pulse.
module tb_demux1_8_serial_rx;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_bit;
  logic       sof;
  logic [7:0] out;
  logic       out_valid;
  logic [2:0] s;
  logic       locked;
  logic       sync_err;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned n_pushed = 0;
  int unsigned n_valid  = 0;
  int unsigned exp_sync = 0;
  int unsigned act_sync = 0;
  logic [7:0]  exp_q[$];

  demux1_8_serial_rx #(.N(8), .SW(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .sof       (sof),
    .out       (out),
    .out_valid (out_valid),
    .s         (s),
    .locked    (locked),
    .sync_err  (sync_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs seen then reflect beats up to the prior rising edge.
  task automatic drive(input logic v, input logic f, input logic b);
    @(negedge clk);
    in_valid = v;
    sof      = f;
    in_bit   = b;
  endtask

  task automatic send_frame(input logic [7:0] w, input int gap_at);
    exp_q.push_back(w);
    n_pushed++;
    for (int i = 0; i < 8; i++) begin
      if (i == gap_at)
        repeat (3) drive(1'b0, 1'($urandom), 1'($urandom));
      drive(1'b1, (i == 0), w[i]);
    end
  endtask

  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (sync_err === 1'b1) act_sync++;
      if (out_valid === 1'b1) begin
        n_valid++;
        if (exp_q.size() == 0) begin
          check("unexpected out_valid", 32'(out_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("out word", 32'(out), 32'(e));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; sof = 1'b0; in_bit = 1'b0;
    #1;
    check("reset out", 32'(out), 32'd0);
    check("reset s", 32'(s), 32'd0);
    check("reset locked", 32'(locked), 32'd0);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset sync_err", 32'(sync_err), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Nominal frame
    send_frame(8'hAA, -1);
    drive(1'b0, 1'b0, 1'b0);
    check("nominal s wrap", 32'(s), 32'd0);
    check("nominal locked", 32'(locked), 32'd1);

    // Back-to-back frames with gaps
    send_frame(8'hAA, 3);
    send_frame(8'h3C, 5);
    repeat (3) drive(1'b0, 1'b0, 1'b0);
    check("b2b sync_err count", act_sync, exp_sync);

    // Pre-lock noise
    @(negedge clk); rst_n = 1'b0; in_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 1'($urandom));
      check("noise locked", 32'(locked), 32'd0);
    end
    send_frame(8'h81, -1);

    // Early sof at slot 4
    for (int i = 0; i < 4; i++) drive(1'b1, (i == 0), 1'b1);
    exp_sync++;
    send_frame(8'h5A, -1);
    drive(1'b0, 1'b0, 1'b0);
    check("early locked", 32'(locked), 32'd1);
    drive(1'b0, 1'b0, 1'b0);
    check("early sync_err count", act_sync, exp_sync);

    // Missing sof at slot 0
    drive(1'b1, 1'b0, 1'b1);
    exp_sync++;
    drive(1'b0, 1'b0, 1'b0);
    check("missing sync_err", 32'(sync_err), 32'd1);
    check("missing locked", 32'(locked), 32'd0);
    drive(1'b0, 1'b0, 1'b0);
    check("missing sync_err width", 32'(sync_err), 32'd0);
    send_frame(8'hF0, -1);

    // Reset mid-frame at slot 5
    for (int i = 0; i < 5; i++) drive(1'b1, (i == 0), 1'b1);
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0;
    #1;
    check("midreset out", 32'(out), 32'd0);
    check("midreset s", 32'(s), 32'd0);
    check("midreset locked", 32'(locked), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send_frame(8'h0F, -1);
    repeat (3) drive(1'b0, 1'b0, 1'b0);

    check("pending words", exp_q.size(), 32'd0);
    check("frame count", n_valid, n_pushed);
    check("total sync_err count", act_sync, exp_sync);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/demux1_8_serial_rx.md
# demux1_8_serial_rx

Receive-side counterpart of the 8:1 select-scanned multiplexer. A transmitter drives `in[s]` for s = 0..7 onto one wire, one bit per beat. This block captures that serial stream slot by slot with a 3-bit select counter and rebuilds the 8-bit parallel word. It sits at the far end of the single-wire link and hands complete words, with a one-cycle valid pulse, to downstream logic.

## Interface
Parameters:
- `N` — default 8 — number of slots/channels per frame; must be a power of 2, at least 2.
- `SW` — default 3 — select counter width; must equal log2(N).

Ports:
- `clk` — input, 1 — single clock; all logic is rising-edge.
- `rst_n` — input, 1 — reset, asynchronous, active-low.
- `in_valid` — input, 1 — the beat on `in_bit`/`sof` is present this cycle.
- `in_bit` — input, 1 — serial data bit for the current slot.
- `sof` — input, 1 — start of frame; marks the slot-0 beat. Qualified by `in_valid`.
- `out` — output, N — last completed word; slot k maps to `out[k]`. Registered.
- `out_valid` — output, 1 — one-cycle pulse when `out` is updated.
- `s` — output, SW — slot index expected for the next accepted beat.
- `locked` — output, 1 — receiver is aligned to frame boundaries.
- `sync_err` — output, 1 — one-cycle pulse on a framing violation.

## Operation
- **Reset values:** state = HUNT, `s` = 0, `out` = 0, shadow register = 0, `out_valid` = 0, `sync_err` = 0, `locked` = 0.
- **Accepted beat:** a cycle with `in_valid` = 1. When `in_valid` = 0, nothing changes: `s`, shadow and state all hold, and `sof` is ignored.
- **HUNT:**
  - Beats with `sof` = 0 are discarded.
  - A beat with `sof` = 1: `shadow[0]` ← `in_bit`, `s` ← 1, state → LOCKED.
- **LOCKED, beat with s ≠ 0 and sof = 0:** `shadow[s]` ← `in_bit`, `s` ← s+1.
- **LOCKED, beat with s = N-1 and sof = 0:**
  - `out` ← {`in_bit`, `shadow[N-2:0]`}.
  - `out_valid` pulses.
  - `s` wraps to 0. The wrap is modulo 2^SW and no explicit compare is needed.
- **LOCKED, beat with s = 0 and sof = 1:** normal frame start. `shadow[0]` ← `in_bit`, `s` ← 1.
- **LOCKED, beat with s ≠ 0 and sof = 1 (early sof):**
  - `sync_err` pulses.
  - The partial frame is discarded and no `out_valid` is produced.
  - Realign: `shadow[0]` ← `in_bit`, `s` ← 1, state stays LOCKED.
- **LOCKED, beat with s = 0 and sof = 0 (missing sof):**
  - `sync_err` pulses.
  - The beat is discarded.
  - State → HUNT, `s` = 0.
- **Shadow bits** not yet written in the current frame keep stale values. They are never visible on `out`, because `out` loads only after all N slots are accepted.
- **`locked`** = 1 exactly while the state is LOCKED.
- **`out`** holds its value between completed frames.

## Timing
- `out` and `out_valid` are registered. They update on the clock edge that accepts slot N-1, so the word is visible in the cycle after that beat is presented.
- `out_valid` is high for exactly one cycle per completed frame, including back-to-back frames.
- **Throughput:** one frame per N accepted beats. Continuous `in_valid` gives a word every N cycles with no bubbles.
- `sync_err` is registered: a one-cycle pulse in the cycle after the offending beat.
- `locked` rises in the cycle after the aligning `sof` beat. It falls in the cycle after a missing-sof beat.
- **Reset asserted mid-frame:** all outputs go to their reset values immediately (asynchronous). The partial frame is lost. After release the block is in HUNT.
- No combinational path exists from inputs to outputs.

## Test plan
- **Nominal frame:** `in` = 8'b10101010 serialized as slots 0..7 = 0,1,0,1,0,1,0,1, with `sof` on slot 0 and `in_valid` held high. Required: `out` = 8'hAA and a single `out_valid` pulse one cycle after the slot-7 beat; `s` returns to 0; `locked` = 1.
- **Back-to-back frames with gaps:** frames 8'hAA then 8'h3C, with `in_valid` dropped for 3 cycles mid-frame and random `sof` toggling during the gaps. Required: `out` = 8'hAA then 8'h3C, with exactly two `out_valid` pulses and no `sync_err`.
- **Pre-lock noise:** 5 beats with `sof` = 0 after reset, then a nominal frame of 8'h81. Required: `locked` = 0 during the noise, then `out` = 8'h81 with one `out_valid`.
- **Early sof:** `sof` reasserted at slot 4, then 8 clean beats carrying 8'h5A. Required: one `sync_err` pulse and no `out_valid` for the partial frame, then `out` = 8'h5A.
- **Missing sof:** after a complete frame, the next slot-0 beat has `sof` = 0. Required: `sync_err` pulses and `locked` drops to 0 the following cycle. A later `sof`-aligned frame of 8'hF0 yields `out` = 8'hF0.
- **Reset mid-frame:** assert `rst_n` = 0 at slot 5 for 2 cycles. Required: `out` = 0, `s` = 0, `locked` = 0 asynchronously. The next clean frame of 8'h0F yields `out` = 8'h0F.
